// File: rtl/load_store_unit.sv
// load_store_unit: memory stage after the ALU. Turns ALU_result into one
// load or store on the data-memory req/ack port, builds byte enables and
// lane-replicated store data, and returns extended load data.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, misaligned half/word
// accesses fault with cause 01 instead of being force-aligned.
//
// Handshake: dmem_req rises the cycle after an op is accepted and stays high,
// with dmem_we/addr/be/wdata held constant, until a cycle in which dmem_ack is
// sampled high on the rising edge; that edge completes the transfer.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALU_result,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;
`ifdef MISALIGN_TRAP_EN
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] ld_q, ld_d;

    // Decode of the incoming op: legality, effective lane offset, enables and data.
    logic        op_legal;
    logic        op_half;
    logic        op_word;
    logic [1:0]  op_off;
    logic [3:0]  op_be;
    logic [31:0] op_wdata;
`ifdef MISALIGN_TRAP_EN
    logic        op_misaligned;
`endif

    // Combinational decode of the op presented by the execute stage.
    always_comb begin
        op_half  = (funct3[1:0] == 2'b01);
        op_word  = (funct3[1:0] == 2'b10);
        op_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: op_legal = 1'b1;
            3'b100, 3'b101:         op_legal = !op_write;
            default:                op_legal = 1'b0;
        endcase
        // Force-aligned lane offset: halves drop bit 0, words drop both bits.
        if (op_word) begin
            op_off = 2'b00;
        end else if (op_half) begin
            op_off = {ALU_result[1], 1'b0};
        end else begin
            op_off = ALU_result[1:0];
        end
        if (op_word) begin
            op_be    = 4'b1111;
            op_wdata = store_data;
        end else if (op_half) begin
            op_be    = op_off[1] ? 4'b1100 : 4'b0011;
            op_wdata = {2{store_data[15:0]}};
        end else begin
            op_be    = 4'b0001 << op_off;
            op_wdata = {4{store_data[7:0]}};
        end
`ifdef MISALIGN_TRAP_EN
        op_misaligned = (op_half && ALU_result[0]) ||
                        (op_word && (ALU_result[1:0] != 2'b00));
`endif
    end

    // Load lane select and sign/zero extension using the latched op.
    logic [31:0] ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Extract the addressed byte/half from the returned word and extend it.
    always_comb begin
        ld_byte = dmem_rdata[8*off_q +: 8];
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    // Next-state logic: accept in IDLE, wait for ack or timeout in REQ, pulse DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        cause_d = cause_q;
        ld_d    = ld_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    we_d    = op_write;
                    f3_d    = funct3;
                    off_d   = op_off;
                    addr_d  = {ALU_result[31:2], 2'b00};
                    be_d    = op_be;
                    wdata_d = op_wdata;
                    ld_d    = 32'd0;
                    cnt_d   = 16'd0;
                    fault_d = 1'b0;
                    cause_d = CAUSE_NONE;
                    if (!op_legal) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                        state_d = S_DONE;
`ifdef MISALIGN_TRAP_EN
                    end else if (op_misaligned) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // An ack in the last allowed cycle still completes cleanly.
                if (dmem_ack) begin
                    ld_d    = we_q ? 32'd0 : ld_ext;
                    fault_d = 1'b0;
                    cause_d = CAUSE_NONE;
                    state_d = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    ld_d    = 32'd0;
                    fault_d = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            fault_q <= 1'b0;
            cause_q <= 2'd0;
            ld_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            ld_q    <= ld_d;
        end
    end

    // Outputs are decoded from registered state so nothing glitches on inputs.
    assign stall       = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign load_data   = done ? ld_q : 32'd0;
    assign fault       = done & fault_q;
    assign fault_cause = done ? cause_q : 2'd0;
    assign dmem_req    = (state_q == S_REQ);
    assign dmem_we     = dmem_req & we_q;
    assign dmem_addr   = dmem_req ? addr_q : 32'd0;
    assign dmem_be     = dmem_req ? be_q : 4'd0;
    assign dmem_wdata  = dmem_req ? wdata_q : 32'd0;
    assign state_dbg   = state_q;

endmodule
